pgpio: RTL and testbench

Parametrised GPIO controller for the Parallella platform top level. It sits beside the elink and the I2C pad logic and is reached through a 104-bit emesh register packet port. It drives up to 32 pins with per-pin direction and output registers, and samples inputs through a synchroniser. It raises one interrupt from per-pin edge or level detection, with mask and polarity control.

---
 rtl/pgpio_pkg.sv | 35 +++
 rtl/pgpio_isync.sv | 30 +++
 rtl/pgpio.sv | 179 +++++++++++++++++
 tb/tb_pgpio.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pgpio_pkg.sv
// Shared definitions for the pgpio GPIO controller: register map, emesh packet
// field positions and the packet struct used by the register port.
package pgpio_pkg;

  localparam logic [3:0] PGPIO_DIR     = 4'd0;
  localparam logic [3:0] PGPIO_OUT     = 4'd1;
  localparam logic [3:0] PGPIO_IN      = 4'd2;
  localparam logic [3:0] PGPIO_IMASK   = 4'd3;
  localparam logic [3:0] PGPIO_ITYPE   = 4'd4;
  localparam logic [3:0] PGPIO_IPOL    = 4'd5;
  localparam logic [3:0] PGPIO_ISTATUS = 4'd6;
  localparam logic [3:0] PGPIO_OUTSET  = 4'd7;
  localparam logic [3:0] PGPIO_OUTCLR  = 4'd8;
  localparam logic [3:0] PGPIO_OUTXOR  = 4'd9;

  localparam int PKT_WRITE_BIT    = 0;
  localparam int PKT_DATAMODE_LSB = 1;
  localparam int PKT_CTRLMODE_LSB = 3;
  localparam int PKT_DSTADDR_LSB  = 8;
  localparam int PKT_DATA_LSB     = 40;
  localparam int PKT_SRCADDR_LSB  = 72;

  localparam logic [1:0] PGPIO_DATAMODE_32 = 2'd2;

  // Field order is MSB first so the struct overlays the 104-bit packet directly.
  typedef struct packed {
    logic [31:0] srcaddr;
    logic [31:0] data;
    logic [31:0] dstaddr;
    logic [4:0]  ctrlmode;
    logic [1:0]  datamode;
    logic        write;
  } emesh_pkt_t;

endpackage

// File: rtl/pgpio_isync.sv
// Multi-stage input synchroniser for the asynchronous GPIO pad inputs.
module pgpio_isync #(
  parameter int WIDTH  = 12,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_r [STAGES];

  // Shift pad values through the synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_r[i] <= '0;
      end
    end else begin
      sync_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/pgpio.sv
// GPIO controller on an emesh register port: direction/output registers, synchronised
// inputs and an edge/level interrupt compiled in only when PGPIO_IRQ_EN is defined.
module pgpio
  import pgpio_pkg::*;
#(
  parameter int          NGPIO       = 12,
  parameter int          PW          = 104,
  parameter logic [11:0] ID          = 12'h810,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_nreset,
  input  logic             access_in,
  input  logic [PW-1:0]    packet_in,
  output logic             wait_out,
  output logic             access_out,
  output logic [PW-1:0]    packet_out,
  input  logic             wait_in,
  input  logic [NGPIO-1:0] gpio_in,
  output logic [NGPIO-1:0] gpio_out,
  output logic [NGPIO-1:0] gpio_dir,
  output logic             gpio_irq
);

  emesh_pkt_t       req_s;
  emesh_pkt_t       resp_s;
  emesh_pkt_t       resp_r;
  logic             access_r;
  logic             accept_s;
  logic             wr_s;
  logic             rd_s;
  logic [3:0]       sel_s;
  logic [NGPIO-1:0] wdata_s;
  logic [NGPIO-1:0] in_s;
  logic [NGPIO-1:0] dir_r;
  logic [NGPIO-1:0] out_r;
  logic [NGPIO-1:0] imask_s;
  logic [NGPIO-1:0] itype_s;
  logic [NGPIO-1:0] ipol_s;
  logic [NGPIO-1:0] istatus_s;
  logic             irq_s;
  logic [31:0]      rdata_s;
  logic             unused_s;

  assign req_s    = packet_in;
  assign wait_out = access_r & wait_in;
  assign accept_s = access_in & ~wait_out & (req_s.dstaddr[31:20] == ID);
  assign wr_s     = accept_s & req_s.write;
  assign rd_s     = accept_s & ~req_s.write;
  assign sel_s    = req_s.dstaddr[5:2];
  assign wdata_s  = req_s.data[NGPIO-1:0];

  // datamode and the unmapped address bits carry no meaning for this block
  assign unused_s = ^{req_s.datamode, req_s.data, req_s.dstaddr[19:6], req_s.dstaddr[1:0]};

  pgpio_isync #(
    .WIDTH  (NGPIO),
    .STAGES (SYNC_STAGES)
  ) u_isync (
    .clk   (sys_clk),
    .rst_n (sys_nreset),
    .d     (gpio_in),
    .q     (in_s)
  );

  // Direction and output registers, including the set/clear/toggle aliases
  always_ff @(posedge sys_clk or negedge sys_nreset) begin
    if (!sys_nreset) begin
      dir_r <= '0;
      out_r <= '0;
    end else if (wr_s) begin
      case (sel_s)
        PGPIO_DIR:    dir_r <= wdata_s;
        PGPIO_OUT:    out_r <= wdata_s;
        PGPIO_OUTSET: out_r <= out_r | wdata_s;
        PGPIO_OUTCLR: out_r <= out_r & ~wdata_s;
        PGPIO_OUTXOR: out_r <= out_r ^ wdata_s;
        default:      ;
      endcase
    end
  end

`ifdef PGPIO_IRQ_EN
  logic [NGPIO-1:0] imask_r;
  logic [NGPIO-1:0] itype_r;
  logic [NGPIO-1:0] ipol_r;
  logic [NGPIO-1:0] istatus_r;
  logic [NGPIO-1:0] prev_r;
  logic [NGPIO-1:0] hit_s;
  logic [NGPIO-1:0] w1c_s;
  logic             irq_r;

  assign hit_s = (itype_r & ((ipol_r & in_s & ~prev_r) | (~ipol_r & ~in_s & prev_r)))
               | (~itype_r & ~(in_s ^ ipol_r));
  assign w1c_s = (wr_s && (sel_s == PGPIO_ISTATUS)) ? wdata_s : '0;

  // Interrupt configuration, sticky status (new events beat W1C) and the irq flop
  always_ff @(posedge sys_clk or negedge sys_nreset) begin
    if (!sys_nreset) begin
      imask_r   <= '0;
      itype_r   <= '0;
      ipol_r    <= '0;
      istatus_r <= '0;
      prev_r    <= '0;
      irq_r     <= 1'b0;
    end else begin
      prev_r    <= in_s;
      istatus_r <= (istatus_r & ~w1c_s) | hit_s;
      irq_r     <= |(istatus_r & imask_r);
      if (wr_s) begin
        case (sel_s)
          PGPIO_IMASK: imask_r <= wdata_s;
          PGPIO_ITYPE: itype_r <= wdata_s;
          PGPIO_IPOL:  ipol_r  <= wdata_s;
          default:     ;
        endcase
      end
    end
  end

  assign imask_s   = imask_r;
  assign itype_s   = itype_r;
  assign ipol_s    = ipol_r;
  assign istatus_s = istatus_r;
  assign irq_s     = irq_r;
`else
  assign imask_s   = '0;
  assign itype_s   = '0;
  assign ipol_s    = '0;
  assign istatus_s = '0;
  assign irq_s     = 1'b0;
`endif

  // Register read mux; write-only aliases and unmapped slots read zero
  always_comb begin
    rdata_s = 32'd0;
    case (sel_s)
      PGPIO_DIR:     rdata_s[NGPIO-1:0] = dir_r;
      PGPIO_OUT:     rdata_s[NGPIO-1:0] = out_r;
      PGPIO_IN:      rdata_s[NGPIO-1:0] = in_s;
      PGPIO_IMASK:   rdata_s[NGPIO-1:0] = imask_s;
      PGPIO_ITYPE:   rdata_s[NGPIO-1:0] = itype_s;
      PGPIO_IPOL:    rdata_s[NGPIO-1:0] = ipol_s;
      PGPIO_ISTATUS: rdata_s[NGPIO-1:0] = istatus_s;
      default:       rdata_s = 32'd0;
    endcase
  end

  // Response packet swaps source and destination so it routes back to the requester
  always_comb begin
    resp_s          = '0;
    resp_s.write    = 1'b1;
    resp_s.datamode = PGPIO_DATAMODE_32;
    resp_s.ctrlmode = req_s.ctrlmode;
    resp_s.dstaddr  = req_s.srcaddr;
    resp_s.data     = rdata_s;
    resp_s.srcaddr  = req_s.dstaddr;
  end

  // Read-response register, held while the consumer stalls
  always_ff @(posedge sys_clk or negedge sys_nreset) begin
    if (!sys_nreset) begin
      access_r <= 1'b0;
      resp_r   <= '0;
    end else if (rd_s) begin
      access_r <= 1'b1;
      resp_r   <= resp_s;
    end else if (!wait_in) begin
      access_r <= 1'b0;
    end
  end

  assign access_out = access_r;
  assign packet_out = resp_r;
  assign gpio_out   = out_r;
  assign gpio_dir   = dir_r;
  assign gpio_irq   = irq_s;

endmodule

// File: tb/tb_pgpio.sv
// Self-checking bench for pgpio: directed register, backpressure and interrupt steps
// followed by randomized register traffic against a behavioural register model.
module tb_pgpio;
  import pgpio_pkg::*;

  localparam int          NG   = 12;
  localparam int          SS   = 2;
  localparam logic [11:0] CHIP = 12'h810;
  localparam logic [11:0] BAD  = 12'h811;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          access_in;
  logic [103:0]  packet_in;
  logic          wait_out;
  logic          access_out;
  logic [103:0]  packet_out;
  logic          wait_in;
  logic [NG-1:0] gpio_in;
  logic [NG-1:0] gpio_out;
  logic [NG-1:0] gpio_dir;
  logic          gpio_irq;

  int errors = 0;
  int checks = 0;

  logic [11:0] dir_m, out_m, in_m, imask_m, itype_m, ipol_m;

  pgpio #(.NGPIO(NG), .PW(104), .ID(CHIP), .SYNC_STAGES(SS)) dut (
    .sys_clk(clk), .sys_nreset(rst_n), .access_in(access_in), .packet_in(packet_in),
    .wait_out(wait_out), .access_out(access_out), .packet_out(packet_out),
    .wait_in(wait_in), .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_dir(gpio_dir),
    .gpio_irq(gpio_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [103:0] obs, input logic [103:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [103:0] mkpkt(input logic w, input logic [3:0] r, input logic [31:0] d,
                                         input logic [11:0] chip, input logic [4:0] ctrl,
                                         input logic [31:0] src);
    logic [31:0] dst;
    dst = {chip, 14'd0, r, 2'd0};
    return {src, d, dst, ctrl, 2'd0, w};
  endfunction

  function automatic logic [103:0] mkresp(input logic [103:0] req, input logic [11:0] d);
    return {req[39:8], 20'd0, d, req[103:72], req[7:3], 2'd2, 1'b1};
  endfunction

  function automatic logic [11:0] model_rd(input logic [3:0] r);
    case (r)
      4'd0: return dir_m;
      4'd1: return out_m;
      4'd2: return in_m;
      4'd3: return imask_m;
      4'd4: return itype_m;
      4'd5: return ipol_m;
      default: return 12'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] r, input logic [31:0] d, input logic [11:0] chip);
    packet_in = mkpkt(1'b1, r, d, chip, 5'd0, 32'd0);
    access_in = 1'b1;
    step();
    access_in = 1'b0;
  endtask

  task automatic rd(input logic [3:0] r, input logic [11:0] exp, input string tag);
    logic [103:0] req;
    req = mkpkt(1'b0, r, $urandom, CHIP, 5'($urandom), $urandom);
    packet_in = req;
    access_in = 1'b1;
    step();
    access_in = 1'b0;
    check({tag, "_valid"}, 104'(access_out), 104'(1'b1));
    check(tag, packet_out, mkresp(req, exp));
    step();
  endtask

  initial begin
    logic [103:0] req;
    logic [103:0] exp_pkt;
    logic [3:0]   wregs [11];
    logic [3:0]   r;
    logic [11:0]  d;
    logic [11:0]  chip;

    wregs = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
    rst_n = 1'b0; access_in = 1'b0; packet_in = '0; wait_in = 1'b0; gpio_in = '0;
    dir_m = '0; out_m = '0; in_m = '0; imask_m = '0; itype_m = '0; ipol_m = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("rst_dir", 104'(gpio_dir), 104'd0);
    check("rst_out", 104'(gpio_out), 104'd0);
    check("rst_irq", 104'(gpio_irq), 104'd0);
    check("rst_access", 104'(access_out), 104'd0);
    check("rst_wait", 104'(wait_out), 104'd0);
    check("rst_packet", packet_out, 104'd0);
    for (int i = 0; i < 10; i++) rd(4'(i), 12'd0, "rst_read");

    // set / clear / toggle aliases
    wr(4'd0, 32'h0000_0FFF, CHIP);
    wr(4'd1, 32'h0000_00F0, CHIP);
    wr(4'd7, 32'h0000_000F, CHIP);
    wr(4'd8, 32'h0000_0030, CHIP);
    wr(4'd9, 32'h0000_0801, CHIP);
    dir_m = 12'hFFF; out_m = 12'h8CE;
    check("alias_out", 104'(gpio_out), 104'(12'h8CE));
    check("alias_dir", 104'(gpio_dir), 104'(12'hFFF));
    rd(4'd1, 12'h8CE, "alias_read");

    gpio_in = 12'hA5C; in_m = 12'hA5C;
    repeat (SS + 1) step();
    rd(4'd2, in_m, "in_read");

    // response backpressure: read of IN stalls, queued write waits
    gpio_in = 12'h5A3; in_m = 12'h5A3;
    repeat (SS + 2) step();
    wait_in = 1'b1;
    req = mkpkt(1'b0, 4'd2, 32'd0, CHIP, 5'h15, 32'hDEAD_BEEF);
    exp_pkt = mkresp(req, 12'h5A3);
    packet_in = req; access_in = 1'b1;
    step();
    packet_in = mkpkt(1'b1, 4'd1, 32'h0000_0123, CHIP, 5'd0, 32'd0);
    gpio_in = 12'h000; in_m = 12'h000;
    for (int i = 0; i < 3; i++) begin
      check("bp_wait", 104'(wait_out), 104'(1'b1));
      check("bp_valid", 104'(access_out), 104'(1'b1));
      check("bp_packet", packet_out, exp_pkt);
      check("bp_out_held", 104'(gpio_out), 104'(out_m));
      step();
    end
    wait_in = 1'b0;
    #1;
    check("bp_wait_drop", 104'(wait_out), 104'd0);
    step();
    access_in = 1'b0;
    out_m = 12'h123;
    check("bp_write", 104'(gpio_out), 104'(out_m));
    check("bp_valid_drop", 104'(access_out), 104'd0);

    // foreign chip ID
    wr(4'd1, 32'h0000_0FFF, BAD);
    check("badid_write", 104'(gpio_out), 104'(out_m));
    packet_in = mkpkt(1'b0, 4'd1, 32'd0, BAD, 5'd3, 32'h1234_5678);
    access_in = 1'b1;
    step();
    access_in = 1'b0;
    check("badid_noresp", 104'(access_out), 104'd0);
    step();

`ifdef PGPIO_IRQ_EN
    // rising edge on pin 0
    wr(4'd4, 32'h0000_0FFF, CHIP);
    wr(4'd5, 32'h0000_0001, CHIP);
    wr(4'd6, 32'h0000_0FFF, CHIP);
    wr(4'd3, 32'h0000_0001, CHIP);
    step();
    check("edge_idle_irq", 104'(gpio_irq), 104'd0);
    gpio_in = 12'h001; in_m = 12'h001;
    repeat (SS + 1) step();
    check("edge_irq_early", 104'(gpio_irq), 104'd0);
    rd(4'd6, 12'h001, "edge_status");
    check("edge_irq", 104'(gpio_irq), 104'(1'b1));
    wr(4'd6, 32'h0000_0001, CHIP);
    check("w1c_irq_lag", 104'(gpio_irq), 104'(1'b1));
    step();
    check("w1c_irq_low", 104'(gpio_irq), 104'd0);
    rd(4'd6, 12'h000, "w1c_status");

    // level-high on pin 2 re-asserts over W1C
    wr(4'd5, 32'h0000_0004, CHIP);
    wr(4'd4, 32'h0000_0000, CHIP);
    wr(4'd3, 32'h0000_0004, CHIP);
    imask_m = 12'h004; itype_m = 12'h000; ipol_m = 12'h004;
    gpio_in = 12'h005; in_m = 12'h005;
    repeat (SS + 2) step();
    check("level_irq", 104'(gpio_irq), 104'(1'b1));
    wr(4'd6, 32'h0000_0004, CHIP);
    check("level_w1c_irq", 104'(gpio_irq), 104'(1'b1));
    step();
    check("level_w1c_irq2", 104'(gpio_irq), 104'(1'b1));
    rd(4'd6, 12'hFFE, "level_status");
`else
    wr(4'd3, 32'h0000_0FFF, CHIP);
    wr(4'd4, 32'h0000_0FFF, CHIP);
    wr(4'd5, 32'h0000_0FFF, CHIP);
    rd(4'd3, 12'd0, "noirq_imask");
    rd(4'd5, 12'd0, "noirq_ipol");
    for (int i = 0; i < 4; i++) begin
      gpio_in = ~gpio_in;
      repeat (SS + 2) step();
      check("noirq_irq", 104'(gpio_irq), 104'd0);
    end
    in_m = gpio_in;
    rd(4'd6, 12'd0, "noirq_status");
`endif

    // randomized register traffic against the model
    for (int i = 0; i < 40; i++) begin
      r    = wregs[$urandom_range(10, 0)];
      d    = 12'($urandom);
      chip = ($urandom_range(3, 0) == 0) ? BAD : CHIP;
      wr(r, {20'($urandom), d}, chip);
      if (chip == CHIP) begin
        case (r)
          4'd0: dir_m = d;
          4'd1: out_m = d;
          4'd7: out_m = out_m | d;
          4'd8: out_m = out_m & ~d;
          4'd9: out_m = out_m ^ d;
          default: ;
        endcase
      end
      check("rand_out", 104'(gpio_out), 104'(out_m));
      check("rand_dir", 104'(gpio_dir), 104'(dir_m));
      if (i % 8 == 7) begin
        gpio_in = 12'($urandom); in_m = gpio_in;
        repeat (SS + 1) step();
      end
      if (i % 4 == 0) begin
        r = 4'($urandom_range(15, 0));
        if (r == 4'd6 || r == 4'd7 || r == 4'd8 || r == 4'd9) r = 4'd2;
        rd(r, model_rd(r), "rand_read");
      end
    end

    // reset while a stalled response is pending
    wait_in = 1'b1;
    packet_in = mkpkt(1'b0, 4'd0, 32'd0, CHIP, 5'd1, 32'h0000_00AA);
    access_in = 1'b1;
    step();
    access_in = 1'b0;
    check("mid_valid", 104'(access_out), 104'(1'b1));
    rst_n = 1'b0;
    #3;
    check("mid_async", 104'(access_out), 104'd0);
    step();
    rst_n = 1'b1;
    wait_in = 1'b0;
    step();
    check("mid_release", 104'(access_out), 104'd0);
    check("mid_out", 104'(gpio_out), 104'd0);
    check("mid_dir", 104'(gpio_dir), 104'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
